// File: rtl/bf16_sub_seq.sv
// Multi-cycle bf16 subtractor (a - b): one-bit-per-cycle alignment and normalisation,
// truncating result, subnormals treated as zero. Flags: [3]=NAN [2]=ZERO [1]=INF [0]=NORM.
module bf16_sub_seq #(
  parameter int EXP_WIDTH  = 8,
  parameter int SIG_WIDTH  = 7,
  parameter int FLAG_WIDTH = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [EXP_WIDTH+SIG_WIDTH:0]      i_data_a,
  input  logic [EXP_WIDTH+SIG_WIDTH:0]      i_data_b,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [EXP_WIDTH+SIG_WIDTH:0]      o_data,
  output logic [FLAG_WIDTH-1:0]             o_flag
);
  localparam int W   = 1 + EXP_WIDTH + SIG_WIDTH;
  localparam int MW  = SIG_WIDTH + 2;
  localparam int SAT = MW + 1;
  localparam int SHW = $clog2(SAT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_NORM  = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  localparam logic [FLAG_WIDTH-1:0] F_NAN  = FLAG_WIDTH'(4'b1000);
  localparam logic [FLAG_WIDTH-1:0] F_ZERO = FLAG_WIDTH'(4'b0100);
  localparam logic [FLAG_WIDTH-1:0] F_INF  = FLAG_WIDTH'(4'b0010);
  localparam logic [FLAG_WIDTH-1:0] F_NORM = FLAG_WIDTH'(4'b0001);
  localparam logic [EXP_WIDTH-1:0]  EMAX   = '1;
  localparam logic [W-1:0]          QNAN   = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};

  logic [2:0]           state;
  logic [W-1:0]         a_q, b_q;
  logic                 sign_r, eff_sub_r;
  logic [EXP_WIDTH-1:0] exp_r;
  logic [MW-1:0]        aug_r, add_r, m_r;
  logic [SHW-1:0]       shift_r;

  logic                 sa, sb;
  logic [EXP_WIDTH-1:0] ea, eb, ediff;
  logic [SIG_WIDTH-1:0] ma, mb;
  logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
  logic [SHW-1:0]       prep_shift;

  assign {sa, ea, ma} = a_q;
  assign {sb, eb, mb} = b_q;
  assign a_nan  = (&ea) && (|ma);
  assign b_nan  = (&eb) && (|mb);
  assign a_inf  = (&ea) && !(|ma);
  assign b_inf  = (&eb) && !(|mb);
  assign a_zero = !(|ea);
  assign b_zero = !(|eb);
  // Magnitude compare on the packed exp/sig field; ties keep a as the augend
  assign a_big  = a_q[W-2:0] >= b_q[W-2:0];
  assign ediff  = a_big ? (ea - eb) : (eb - ea);
  assign prep_shift = (ediff >= EXP_WIDTH'(SAT)) ? SHW'(SAT) : ediff[SHW-1:0];

  assign o_ready = (state == S_IDLE);

  logic                  fin;
  logic [W-1:0]          fin_data;
  logic [FLAG_WIDTH-1:0] fin_flag;
  logic [MW:0]           sum;
  logic [MW-1:0]         sh;
  logic [EXP_WIDTH-1:0]  e_up, e_dn;

  always_comb begin
    fin      = 1'b0;
    fin_data = '0;
    fin_flag = '0;
    sum  = eff_sub_r ? ({1'b0, aug_r} - {1'b0, add_r}) : ({1'b0, aug_r} + {1'b0, add_r});
    sh   = {m_r[MW-2:0], 1'b0};
    e_up = exp_r + 1'b1;
    e_dn = exp_r - 1'b1;
    case (state)
      S_PREP: begin
        fin = 1'b1;
        if (a_nan || b_nan) begin
          fin_data = b_nan ? b_q : a_q;                 fin_flag = F_NAN;
        end else if (a_zero && b_zero) begin
          fin_data = {sa & ~sb, {(W-1){1'b0}}};         fin_flag = F_ZERO;
        end else if (b_zero) begin
          fin_data = a_q;                               fin_flag = F_ZERO;
        end else if (a_zero) begin
          fin_data = {~sb, b_q[W-2:0]};                 fin_flag = F_ZERO;
        end else if (a_inf && b_inf && (sa == sb)) begin
          fin_data = QNAN;                              fin_flag = F_NAN;
        end else if (a_inf) begin
          fin_data = a_q;                               fin_flag = F_INF;
        end else if (b_inf) begin
          fin_data = {~sb, b_q[W-2:0]};                 fin_flag = F_INF;
        end else begin
          fin = 1'b0;
        end
      end
      S_ADD: begin
        fin = 1'b1;
        if (sum[MW]) begin
          if (e_up == EMAX) begin
            fin_data = {sign_r, EMAX, {SIG_WIDTH{1'b0}}}; fin_flag = F_INF;
          end else begin
            fin_data = {sign_r, e_up, sum[MW-1:2]};       fin_flag = F_NORM;
          end
        end else if (sum == '0) begin
          fin_flag = F_ZERO;
        end else if (sum[MW-1]) begin
          fin_data = {sign_r, exp_r, sum[MW-2:1]};        fin_flag = F_NORM;
        end else begin
          fin = 1'b0;
        end
      end
      S_NORM: begin
        fin = 1'b1;
        if (e_dn == '0) begin
          fin_data = {sign_r, {(W-1){1'b0}}};             fin_flag = F_ZERO;
        end else if (sh[MW-1]) begin
          fin_data = {sign_r, e_dn, sh[MW-2:1]};          fin_flag = F_NORM;
        end else begin
          fin = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_flag  <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_valid) begin
          a_q   <= i_data_a;
          b_q   <= i_data_b;
          state <= S_PREP;
        end
        S_PREP: begin
          // b's sign is inverted here; everything downstream is an add
          sign_r    <= a_big ? sa : ~sb;
          exp_r     <= a_big ? ea : eb;
          aug_r     <= a_big ? {1'b1, ma, 1'b0} : {1'b1, mb, 1'b0};
          add_r     <= a_big ? {1'b1, mb, 1'b0} : {1'b1, ma, 1'b0};
          eff_sub_r <= (sa == sb);
          shift_r   <= prep_shift;
          state     <= (prep_shift == '0) ? S_ADD : S_ALIGN;
        end
        S_ALIGN: begin
          if (shift_r == SHW'(SAT)) begin
            add_r   <= '0;
            shift_r <= '0;
            state   <= S_ADD;
          end else begin
            add_r   <= add_r >> 1;
            shift_r <= shift_r - 1'b1;
            if (shift_r == SHW'(1)) state <= S_ADD;
          end
        end
        S_ADD: begin
          m_r   <= sum[MW-1:0];
          state <= S_NORM;
        end
        S_NORM: begin
          m_r   <= sh;
          exp_r <= e_dn;
        end
        S_OUT: if (i_ready) begin
          o_valid <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (fin) begin
        o_data  <= fin_data;
        o_flag  <= fin_flag;
        o_valid <= 1'b1;
        state   <= S_OUT;
      end
    end
  end
endmodule

// File: tb/tb_bf16_sub_seq.sv
// Bench for bf16_sub_seq: directed cases, random operands vs an integer reference model,
// back-pressure, back-to-back traffic and reset during alignment.
module tb_bf16_sub_seq;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] i_data_a = '0;
  logic [15:0] i_data_b = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [15:0] o_data;
  logic [3:0]  o_flag;

  int checks = 0;
  int errors = 0;

  bf16_sub_seq dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_flag(o_flag)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference: a + (-b) on integer mantissas, alignment truncation, then normalise.
  function automatic void ref_sub(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] d, output logic [3:0] f);
    logic [15:0] nb, big, sml;
    int ea, eb, e, dexp, ra, rb, r;
    logic s;
    nb = b ^ 16'h8000;
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    d = 16'h0; f = 4'b0;
    if ((ea == 255 && a[6:0] != 0) || (eb == 255 && b[6:0] != 0)) begin
      d = (eb == 255 && b[6:0] != 0) ? b : a; f = 4'b1000; return;
    end
    if (ea == 0 && eb == 0) begin d = {a[15] & nb[15], 15'h0}; f = 4'b0100; return; end
    if (eb == 0) begin d = a;  f = 4'b0100; return; end
    if (ea == 0) begin d = nb; f = 4'b0100; return; end
    if (ea == 255 && eb == 255 && a[15] == b[15]) begin d = 16'h7FC0; f = 4'b1000; return; end
    if (ea == 255) begin d = a;  f = 4'b0010; return; end
    if (eb == 255) begin d = nb; f = 4'b0010; return; end
    if (a[14:0] >= b[14:0]) begin big = a; sml = nb; end
    else begin big = nb; sml = a; end
    s    = big[15];
    e    = int'(big[14:7]);
    dexp = e - int'(sml[14:7]);
    ra   = (128 + int'(big[6:0])) * 2;
    rb   = (dexp >= 10) ? 0 : (((128 + int'(sml[6:0])) * 2) >> dexp);
    r    = (big[15] == sml[15]) ? ra + rb : ra - rb;
    if (r == 0) begin d = 16'h0000; f = 4'b0100; return; end
    if (r >= 512) begin
      r = r / 2; e++;
      if (e >= 255) begin d = {s, 8'hFF, 7'h0}; f = 4'b0010; return; end
    end
    while (r < 256) begin
      r = r * 2; e--;
      if (e == 0) begin d = {s, 15'h0}; f = 4'b0100; return; end
    end
    d = {s, 8'(e), 7'(r >> 1)};
    f = 4'b0001;
  endfunction

  // One transaction: wait for o_ready, present operands, wait for o_valid, stall, consume.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                        output logic [15:0] d, output logic [3:0] f,
                        output int lat, output bit tmo, output bit post_idle);
    int n;
    tmo = 1'b0; n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 50) begin @(negedge i_clk); n++; end
    if (!o_ready) tmo = 1'b1;
    i_data_a = a; i_data_b = b; i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 60) begin @(negedge i_clk); lat++; end
    if (!o_valid) tmo = 1'b1;
    d = o_data; f = o_flag;
    repeat (hold) @(negedge i_clk);
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    post_idle = !o_valid && o_ready;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
    checks++; if (o_data !== 16'h0) begin errors++; $display("FAIL reset_o_data got %h want 0000", o_data); end
    checks++; if (o_flag !== 4'h0) begin errors++; $display("FAIL reset_o_flag got %b want 0000", o_flag); end
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_o_ready got %b want 1", o_ready); end
  endtask

  task automatic test_directed();
    logic [15:0] va [7] = '{16'h4040, 16'h3F80, 16'h3F80, 16'h3F80, 16'h7F7F, 16'h7F80, 16'h7FC1};
    logic [15:0] vb [7] = '{16'h3F80, 16'h3F81, 16'hBF80, 16'h3F80, 16'hFF7F, 16'h7F80, 16'h3F80};
    logic [15:0] vd [7] = '{16'h4000, 16'hBC00, 16'h4000, 16'h0000, 16'h7F80, 16'h7FC0, 16'h7FC1};
    logic [3:0]  vf [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0010, 4'b1000, 4'b1000};
    int          vl [7] = '{4, -1, -1, -1, -1, 2, -1};
    logic [15:0] d; logic [3:0] f; int lat; bit tmo, pi;
    for (int i = 0; i < 7; i++) begin
      run_op(va[i], vb[i], 0, d, f, lat, tmo, pi);
      checks++; if (tmo) begin errors++; $display("FAIL dir%0d_timeout got timeout want result", i); end
      checks++; if (d !== vd[i]) begin errors++; $display("FAIL dir%0d_data %h-%h got %h want %h", i, va[i], vb[i], d, vd[i]); end
      checks++; if (f !== vf[i]) begin errors++; $display("FAIL dir%0d_flag got %b want %b", i, f, vf[i]); end
      if (vl[i] >= 0) begin
        checks++; if (lat !== vl[i]) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, vl[i]); end
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [15:0] sp [6] = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC0, 16'h0012};
    logic [15:0] a, b, d, ed; logic [3:0] f, ef; int lat; bit tmo, pi;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'($urandom);
        1: b = {1'($urandom), a[14:7], 7'($urandom)};
        2: b = {1'($urandom), 8'(int'(a[14:7]) + int'($urandom_range(0, 12)) - 6), 7'($urandom)};
        default: b = sp[$urandom_range(0, 5)];
      endcase
      if ($urandom_range(0, 1) == 1) {a, b} = {b, a};
      ref_sub(a, b, ed, ef);
      run_op(a, b, int'($urandom_range(0, 2)), d, f, lat, tmo, pi);
      checks++; if (tmo) begin errors++; $display("FAIL rand_timeout %h-%h got timeout want result", a, b); end
      checks++; if (d !== ed) begin errors++; $display("FAIL rand_data %h-%h got %h want %h", a, b, d, ed); end
      checks++; if (f !== ef) begin errors++; $display("FAIL rand_flag %h-%h got %b want %b", a, b, f, ef); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b, d, ed; logic [3:0] f, ef; int lat; bit tmo, pi;
    for (int i = 0; i < 16; i++) begin
      a = {1'($urandom), 8'($urandom_range(100, 150)), 7'($urandom)};
      b = {1'($urandom), 8'($urandom_range(100, 150)), 7'($urandom)};
      ref_sub(a, b, ed, ef);
      run_op(a, b, 0, d, f, lat, tmo, pi);
      checks++; if (tmo || d !== ed || f !== ef) begin
        errors++; $display("FAIL b2b_result %h-%h got %h/%b want %h/%b", a, b, d, f, ed, ef);
      end
      checks++; if (pi !== 1'b1) begin errors++; $display("FAIL b2b_release got busy want idle"); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge i_clk);
    i_data_a = 16'h4040; i_data_b = 16'h3F80; i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0; n = 0;
    while (!o_valid && n < 60) begin @(negedge i_clk); n++; end
    checks++; if (!o_valid) begin errors++; $display("FAIL bp_timeout got no o_valid want o_valid"); end
    i_data_a = 16'h4100; i_data_b = 16'h3F00; i_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d got %b want 1", c, o_valid); end
      checks++; if (o_data !== 16'h4000) begin errors++; $display("FAIL bp_data c%0d got %h want 4000", c, o_data); end
      checks++; if (o_flag !== 4'b0001) begin errors++; $display("FAIL bp_flag c%0d got %b want 0001", c, o_flag); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready c%0d got %b want 0", c, o_ready); end
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_drop got %b want 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_idle got %b want 1", o_ready); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; logic [3:0] f; int lat; bit tmo, pi, seen;
    @(negedge i_clk);
    i_data_a = 16'h4400; i_data_b = 16'h3F80; i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", o_valid); end
    checks++; if (o_data !== 16'h0) begin errors++; $display("FAIL rstmid_data got %h want 0000", o_data); end
    checks++; if (o_flag !== 4'h0) begin errors++; $display("FAIL rstmid_flag got %b want 0000", o_flag); end
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", o_ready); end
    seen = 1'b0;
    repeat (20) begin @(negedge i_clk); if (o_valid) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL rstmid_stale got o_valid want none"); end
    run_op(16'h4040, 16'h3F80, 0, d, f, lat, tmo, pi);
    checks++; if (tmo || d !== 16'h4000 || f !== 4'b0001) begin
      errors++; $display("FAIL rstmid_next got %h/%b want 4000/0001", d, f);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random(300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
